btb_branch_predictor: RTL
=========================

Name: btb_branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating direction counters for the RV32I pipeline.
- Fetch side: looks up PCF combinationally and gives the next-PC mux a predicted-taken flag and predicted target in the same cycle.
- Execute side: takes resolved conditional-branch outcomes, updates the table, and flags mispredictions so the next-PC mux can redirect and the hazard unit can flush IF/ID.

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, 4..1024.
- IDX_W, log2(ENTRIES), index width; derived, not overridable.
- TAG_W, 30-IDX_W, tag width taken from PC[31:2+IDX_W].

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- PCF  in  32  fetch-stage PC.
- PredTakenF  out  1  lookup hit and counter MSB=1.
- PredTargetF  out  32  stored target on hit, else PCF+4.
- BranchValidE  in  1  conditional branch resolved in EX this cycle.
- BranchTakenE  in  1  actual direction.
- PCE  in  32  PC of the EX branch.
- BranchTargetE  in  32  actual taken target.
- PredTakenE  in  1  PredTakenF carried down the pipeline with the branch.
- PredTargetE  in  32  PredTargetF carried down the pipeline with the branch.
- MispredictE  out  1  redirect and flush request.
- RedirectPCE  out  32  correct next PC: BranchTargetE if taken, else PCE+4.
- BranchCount  out  32  resolved-branch counter, saturating.
- MissCount  out  32  mispredict counter, saturating.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[31:2], ctr[1:0]. Index = PC[2+IDX_W-1:2]. Target low two bits read as 00.
- Reset (rst_n=0 at posedge):
  - all valid=0, all ctr=01 (weakly not-taken), BranchCount=0, MissCount=0.
  - Combinational outputs follow from the reset state: PredTakenF=0, PredTargetF=PCF+4.
  - While rst_n=0, no table or counter updates occur regardless of BranchValidE.
- Lookup: purely combinational, zero latency. hit = valid && tag match.
- Mispredict (combinational, qualified by BranchValidE):
  - MispredictE = BranchTakenE!=PredTakenE, OR (BranchTakenE && PredTakenE && BranchTargetE!=PredTargetE).
  - MispredictE=0 when BranchValidE=0; RedirectPCE is don't-care then but must equal PCE+4 or BranchTargetE per the taken rule.
- Update at posedge when BranchValidE=1:
  - Hit at index(PCE): ctr saturating +1 if taken, -1 if not (11 and 00 hold). Target rewritten when taken.
  - Miss and taken: allocate/replace entry; valid=1, tag, target, ctr=10.
  - Miss and not taken: no change.
- Counters:
  - BranchCount += 1 per valid branch.
  - MissCount += 1 per MispredictE.
  - Both saturate at 0xFFFFFFFF.
- Same-index read/write in one cycle: lookup sees pre-update contents; the new value is visible the next cycle. No bypass.
- Aliasing: a tag mismatch is a miss. A non-branch PC that aliases a valid entry is never updated because BranchValidE=0.
- JAL/JALR are not handled here; the next-PC mux gives them priority over the prediction.

Decomposition:
- Shared package bp_pkg holds:
  - counter encodings SNT=00, WNT=01, WT=10, ST=11;
  - entry struct/typedef;
  - function idx_of(pc), function tag_of(pc).
- One sub-module: bp_sat_counter, a combinational 2-bit saturating next-state (ctr, taken -> ctr_next), instantiated once on the update path.

Test Plan:
- Reset, then lookup PCF=0x100 -> PredTakenF=0, PredTargetF=0x104, counters 0.
- Taken branch PCE=0x100, target 0x200, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x200. Next cycle, PCF=0x100 -> PredTakenF=1, PredTargetF=0x200, MissCount=1.
- Counter walk at 0x100 (ctr=10): not-taken twice, then PCF=0x100 -> PredTakenF=0 (ctr=00); a third not-taken holds ctr at 00; two taken -> PredTakenF=1.
- Alias test with ENTRIES=64: a taken branch at 0x100 allocates; then lookup PCF=0x200 (same index, different tag) -> miss, PredTargetF=0x204. A taken branch at 0x200 replaces the entry, so 0x100 then misses.
- Target change at 0x100 (ctr=11): taken to 0x300 with PredTakenE=1, PredTargetE=0x200 -> MispredictE=1, RedirectPCE=0x300; the entry target updates to 0x300.
- Same cycle, PCF=PCE=0x100 with an allocating update -> this cycle's lookup misses and the next cycle hits. Assert rst_n=0 mid-sequence -> next cycle all lookups miss and counters read 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB branch predictor: counter encodings,
// the per-entry record and PC index/tag extraction.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // The tag is kept in its own array because its width depends on ENTRIES.
    typedef struct packed {
        logic        valid;
        logic [29:0] target;
        logic [1:0]  ctr;
    } bp_entry_t;

    // Returns the table index in the low idx_w bits, zero above.
    function automatic logic [31:0] idx_of(input logic [31:0] pc, input int unsigned idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (pc >> 2) & mask;
    endfunction

    // Returns PC[31:2+idx_w] right-justified.
    function automatic logic [31:0] tag_of(input logic [31:0] pc, input int unsigned idx_w);
        return pc >> (2 + idx_w);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating branch direction counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) begin
                ctr_o = ctr_i + 2'd1;
            end
        end else if (ctr_i != SNT) begin
            ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/btb_branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency fetch lookup,
// execute-stage update, mispredict detection and saturating statistics counters.
module btb_branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        BranchValidE,
    input  logic        BranchTakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] RedirectPCE,
    output logic [31:0] BranchCount,
    output logic [31:0] MissCount
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    bp_entry_t        entry_q [ENTRIES];
    bp_entry_t        entry_d [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [TAG_W-1:0] tag_d   [ENTRIES];
    logic [31:0]      branch_cnt_q, branch_cnt_d;
    logic [31:0]      miss_cnt_q, miss_cnt_d;

    logic [31:0]      idx_f_full, tag_f_full, idx_e_full, tag_e_full;
    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e;
    logic [1:0]       ctr_next;
    logic             unused_pc_bits;

    assign idx_f_full = idx_of(PCF, IDX_W);
    assign tag_f_full = tag_of(PCF, IDX_W);
    assign idx_e_full = idx_of(PCE, IDX_W);
    assign tag_e_full = tag_of(PCE, IDX_W);
    assign idx_f      = idx_f_full[IDX_W-1:0];
    assign tag_f      = tag_f_full[TAG_W-1:0];
    assign idx_e      = idx_e_full[IDX_W-1:0];
    assign tag_e      = tag_e_full[TAG_W-1:0];

    // Helper results are zero-extended to 32 bits; the upper bits carry nothing.
    assign unused_pc_bits = ^{idx_f_full[31:IDX_W], tag_f_full[31:TAG_W],
                              idx_e_full[31:IDX_W], tag_e_full[31:TAG_W]};

    // Fetch lookup reads the registered table, so same-cycle updates are not bypassed.
    assign hit_f       = entry_q[idx_f].valid && (tag_q[idx_f] == tag_f);
    assign PredTakenF  = hit_f && entry_q[idx_f].ctr[1];
    assign PredTargetF = hit_f ? {entry_q[idx_f].target, 2'b00} : PCF + 32'd4;

    assign hit_e = entry_q[idx_e].valid && (tag_q[idx_e] == tag_e);

    assign MispredictE = BranchValidE &&
                         ((BranchTakenE != PredTakenE) ||
                          (BranchTakenE && PredTakenE && (BranchTargetE != PredTargetE)));
    assign RedirectPCE = BranchTakenE ? BranchTargetE : PCE + 32'd4;

    bp_sat_counter u_sat_counter (
        .ctr_i   (entry_q[idx_e].ctr),
        .taken_i (BranchTakenE),
        .ctr_o   (ctr_next)
    );

    always_comb begin
        entry_d = entry_q;
        tag_d   = tag_q;
        if (BranchValidE) begin
            if (hit_e) begin
                entry_d[idx_e].ctr = ctr_next;
                if (BranchTakenE) begin
                    entry_d[idx_e].target = BranchTargetE[31:2];
                end
            end else if (BranchTakenE) begin
                entry_d[idx_e].valid  = 1'b1;
                entry_d[idx_e].target = BranchTargetE[31:2];
                entry_d[idx_e].ctr    = WT;
                tag_d[idx_e]          = tag_e;
            end
        end
    end

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (BranchValidE && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (MispredictE && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entry_q[i].valid  <= 1'b0;
                entry_q[i].target <= '0;
                entry_q[i].ctr    <= WNT;
                tag_q[i]          <= '0;
            end
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            entry_q      <= entry_d;
            tag_q        <= tag_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign BranchCount = branch_cnt_q;
    assign MissCount   = miss_cnt_q;

endmodule
